image_scan_ctrl: RTL and testbench

- Parametrised successor to the FPGA-test image controller: walks a COLS x ROWS pixel raster, accepts one pixel per handshake and emits it with its coordinates through a one-stage registered output with valid/ready.
- Adds configurable geometry and data width, reverse scan, continuous (wrap) mode, backpressure and a frame-done pulse.
- Sits between a pixel source (button/UART-fed test data) and a display/sink.
- At FPGA top level, the coordinates drive the left/right LEDs and at_end drives red.

---
 rtl/image_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_image_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/image_scan_ctrl.sv
// Raster scan controller: walks a COLS x ROWS frame, accepting one pixel per
// handshake and re-emitting it with its coordinates from a registered output stage.
module image_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int COL_W  = $clog2(COLS),
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              mode_cont,
  input  logic              dir_rev,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [COL_W-1:0]  out_col,
  output logic [ROW_W-1:0]  out_row,
  output logic              at_end,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                dir_q, dir_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [COL_W-1:0]    out_col_q, out_col_d;
  logic [ROW_W-1:0]    out_row_q, out_row_d;
  logic                at_end_q, at_end_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                is_last;
  logic [COL_W-1:0]    col_nxt;
  logic [ROW_W-1:0]    row_nxt;

  // The output register may refill in the same cycle it drains.
  assign in_ready = (state_q == S_SCAN) & enable & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    is_last = dir_q ? ((col_q == '0) && (row_q == '0))
                    : ((col_q == COL_LAST) && (row_q == ROW_LAST));
    col_nxt = col_q;
    row_nxt = row_q;
    // Explicit end-of-row compares so non-power-of-2 geometry wraps correctly.
    if (dir_q) begin
      if (col_q == '0) begin
        col_nxt = COL_LAST;
        row_nxt = row_q - ROW_W'(1);
      end else begin
        col_nxt = col_q - COL_W'(1);
      end
    end else begin
      if (col_q == COL_LAST) begin
        col_nxt = '0;
        row_nxt = row_q + ROW_W'(1);
      end else begin
        col_nxt = col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    dir_d        = dir_q;
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    frame_done_d = 1'b0;

    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          dir_d   = dir_rev;
          col_d   = dir_rev ? COL_LAST : '0;
          row_d   = dir_rev ? ROW_LAST : '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (accept) begin
          data_out_d  = data_in;
          out_col_d   = col_q;
          out_row_d   = row_q;
          out_valid_d = 1'b1;
          if (is_last) begin
            frame_done_d = 1'b1;
            if (mode_cont) begin
              col_d = dir_q ? COL_LAST : '0;
              row_d = dir_q ? ROW_LAST : '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            col_d = col_nxt;
            row_d = row_nxt;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d      = S_IDLE;
      col_d        = '0;
      row_d        = '0;
      dir_d        = 1'b0;
      out_valid_d  = 1'b0;
      data_out_d   = '0;
      out_col_d    = '0;
      out_row_d    = '0;
      frame_done_d = 1'b0;
    end

    at_end_d = (state_d == S_DONE);
    busy_d   = (state_d == S_SCAN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      dir_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      at_end_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      dir_q        <= dir_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      at_end_q     <= at_end_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign at_end     = at_end_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Directed bench for image_scan_ctrl on a 4x3 raster.
module tb_image_scan_ctrl;

  localparam int DATA_W = 16;
  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              reset, enable, clear, mode_cont, dir_rev, in_valid, out_ready;
  logic              in_ready, out_valid, at_end, frame_done, busy;
  logic [DATA_W-1:0] data_in, data_out;
  logic [COL_W-1:0]  out_col;
  logic [ROW_W-1:0]  out_row;

  int errors = 0;
  int checks = 0;
  int fd_cnt;

  always #5 clk = ~clk;

  image_scan_ctrl #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .mode_cont(mode_cont), .dir_rev(dir_rev),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .out_col(out_col), .out_row(out_row),
    .at_end(at_end), .frame_done(frame_done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int d, input int c, input int r);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(data_out),  32'(d));
    chk({tag, ".col"},   32'(out_col),   32'(c));
    chk({tag, ".row"},   32'(out_row),   32'(r));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid),  32'd0);
    chk({tag, ".data"},  32'(data_out),   32'd0);
    chk({tag, ".col"},   32'(out_col),    32'd0);
    chk({tag, ".row"},   32'(out_row),    32'd0);
    chk({tag, ".end"},   32'(at_end),     32'd0);
    chk({tag, ".fd"},    32'(frame_done), 32'd0);
    chk({tag, ".busy"},  32'(busy),       32'd0);
  endtask

  initial begin
    reset = 1; enable = 0; clear = 0; mode_cont = 0; dir_rev = 0;
    in_valid = 0; out_ready = 1; data_in = '0;
    cyc(); cyc();
    reset = 0;
    cyc();
    chk_zero("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd0);

    // Forward single frame, stop in DONE
    enable = 1; in_valid = 1; data_in = 16'd0;
    #1 chk("idle.in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("fwd.busy", 32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      data_in = 16'(i);
      #1 chk("fwd.in_ready", 32'(in_ready), 32'd1);
      cyc();
      chk_out("fwd", i, i % COLS, i / COLS);
      chk("fwd.fd", 32'(frame_done), 32'(i == 11));
    end
    chk("fwd.at_end", 32'(at_end), 32'd1);
    chk("fwd.done_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("fwd.fd_pulse_end", 32'(frame_done), 32'd0);
    chk("fwd.drain", 32'(out_valid), 32'd0);
    chk("fwd.at_end_hold", 32'(at_end), 32'd1);
    cyc();
    chk("fwd.done_sticky", 32'(at_end), 32'd1);
    reset = 1; cyc(); reset = 0;
    chk_zero("reset_done");

    // Reverse single frame; dir_rev change mid-scan must be ignored
    enable = 1; dir_rev = 1; in_valid = 1;
    cyc();
    dir_rev = 0;
    for (int k = 0; k < 12; k++) begin
      data_in = 16'(100 + k);
      cyc();
      chk_out("rev", 100 + k, (11 - k) % COLS, (11 - k) / COLS);
      chk("rev.fd", 32'(frame_done), 32'(k == 11));
    end
    chk("rev.at_end", 32'(at_end), 32'd1);
    clear = 1; in_valid = 0; enable = 0;
    cyc();
    clear = 0;
    chk("clr_done.at_end", 32'(at_end), 32'd0);
    chk("clr_done.busy", 32'(busy), 32'd0);

    // Continuous mode: 30 pixels, wrap without a bubble
    enable = 1; mode_cont = 1; in_valid = 1; fd_cnt = 0;
    cyc();
    for (int k = 0; k < 30; k++) begin
      data_in = 16'(200 + k);
      cyc();
      chk_out("cont", 200 + k, (k % 12) % COLS, (k % 12) / COLS);
      chk("cont.fd", 32'(frame_done), 32'((k == 11) || (k == 23)));
      chk("cont.at_end", 32'(at_end), 32'd0);
      if (frame_done) fd_cnt++;
    end
    chk("cont.fd_count", 32'(fd_cnt), 32'd2);
    in_valid = 0; clear = 1; enable = 0; mode_cont = 0;
    cyc();
    clear = 0;

    // Backpressure, pause and clear
    enable = 1; in_valid = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      data_in = 16'(i);
      cyc();
      chk_out("bp.pre", i, i, 0);
    end
    out_ready = 0; data_in = 16'd3;
    for (int n = 0; n < 5; n++) begin
      #1 chk("bp.in_ready", 32'(in_ready), 32'd0);
      cyc();
      chk_out("bp.hold", 2, 2, 0);
    end
    out_ready = 1;
    #1 chk("bp.resume_ready", 32'(in_ready), 32'd1);
    cyc();
    chk_out("bp.px3", 3, 3, 0);
    data_in = 16'd4; cyc(); chk_out("px4", 4, 0, 1);
    data_in = 16'd5; cyc(); chk_out("px5", 5, 1, 1);
    enable = 0; data_in = 16'd6;
    for (int n = 0; n < 3; n++) begin
      #1 chk("pause.in_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("pause.drain", 32'(out_valid), 32'd0);
    end
    enable = 1;
    cyc();
    chk_out("px6", 6, 2, 1);
    data_in = 16'd7; cyc(); chk_out("px7", 7, 3, 1);
    clear = 1; in_valid = 0;
    cyc();
    clear = 0;
    chk_zero("clear");
    in_valid = 1; data_in = 16'd8;
    cyc();
    chk("restart.busy", 32'(busy), 32'd1);
    cyc();
    chk_out("restart", 8, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
